// File: rtl/node_unary_mac.sv
// node_unary_mac -- multi-channel unary multiply-accumulate node.
//
// Each accepted input beat carries NCH pairs of thermometer-coded unary
// operands. The node walks the channels one per cycle, multiplies the
// popcounts of each pair and adds the product into an accumulator. Beats
// accumulate until one flagged last; the frame sum is then held on a
// valid/ready output until the consumer takes it.
//
// Build option:
//   NODE_UNARY_MAC_SAT_EN  defined   -> accumulator clamps at 2^ACC_W-1 on overflow
//                          undefined -> accumulator wraps modulo 2^ACC_W
//   out_ovf reports the carry in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   node can accept a beat (IDLE only)
//   in_a/in_b  NCH*UWIDTH operands, channel c at [c*UWIDTH +: UWIDTH]
//   in_last    beat closes the accumulation frame
//   out_valid  frame result valid (HOLD)
//   out_ready  consumer accepts the result
//   out_sum    frame dot-product sum
//   out_ovf    accumulator carried past ACC_W bits during the frame
//   out_err    some operand in the frame was not a legal thermometer code

module node_unary_mac #(
    parameter int UWIDTH = 4,
    parameter int NCH    = 4,
    parameter int ACC_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NCH*UWIDTH-1:0]   in_a,
    input  logic [NCH*UWIDTH-1:0]   in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum,
    output logic                    out_ovf,
    output logic                    out_err
);

    localparam int PCW = $clog2(UWIDTH + 1);
    localparam int PW  = 2 * PCW;
    localparam int CIW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Number of ones in a unary operand.
    function automatic logic [PCW-1:0] popcount_f(input logic [UWIDTH-1:0] v);
        logic [PCW-1:0] cnt;
        cnt = {PCW{1'b0}};
        for (int i = 0; i < UWIDTH; i++) begin
            cnt = cnt + PCW'(v[i]);
        end
        return cnt;
    endfunction

    // Legal thermometer code: ones packed contiguously from the LSB (zero is legal).
    function automatic logic therm_ok_f(input logic [UWIDTH-1:0] v);
        logic seen_zero;
        logic ok;
        seen_zero = 1'b0;
        ok        = 1'b1;
        for (int i = 0; i < UWIDTH; i++) begin
            if (!v[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    state_t                  state_q, state_d;
    logic [NCH*UWIDTH-1:0]   a_q, a_d;
    logic [NCH*UWIDTH-1:0]   b_q, b_d;
    logic                    last_q, last_d;
    logic [CIW-1:0]          ch_idx_q, ch_idx_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;

    logic [UWIDTH-1:0]       a_ch_s, b_ch_s;
    logic [PCW-1:0]          pc_a_s, pc_b_s;
    logic [PW-1:0]           prod_s;
    logic [ACC_W:0]          prod_ext_s;
    logic [ACC_W:0]          sum_s;
    logic                    carry_s;
    logic                    last_ch_s;

    // Select the operand pair of the channel currently being processed.
    always_comb begin
        a_ch_s = {UWIDTH{1'b0}};
        b_ch_s = {UWIDTH{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            if (ch_idx_q == CIW'(c)) begin
                a_ch_s = a_q[c*UWIDTH +: UWIDTH];
                b_ch_s = b_q[c*UWIDTH +: UWIDTH];
            end else begin
                a_ch_s = a_ch_s;
                b_ch_s = b_ch_s;
            end
        end
    end

    assign pc_a_s     = popcount_f(a_ch_s);
    assign pc_b_s     = popcount_f(b_ch_s);
    assign prod_s     = PW'(pc_a_s) * PW'(pc_b_s);
    assign prod_ext_s = (ACC_W + 1)'(prod_s);
    // One spare bit on the adder exposes the carry out of the accumulator.
    assign sum_s      = {1'b0, acc_q} + prod_ext_s;
    assign carry_s    = sum_s[ACC_W];
    assign last_ch_s  = (ch_idx_q == CIW'(NCH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_ch_s) begin
                    state_d = last_q ? ST_HOLD : ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_MUL:  in_ready  = 1'b0;
            ST_HOLD: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_sum = acc_q;
    assign out_ovf = ovf_q;
    assign out_err = err_q;

    // Datapath next-state: capture, per-channel accumulate, frame clear.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        last_d   = last_q;
        ch_idx_d = ch_idx_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    last_d   = in_last;
                    ch_idx_d = {CIW{1'b0}};
                end else begin
                    ch_idx_d = ch_idx_q;
                end
            end
            ST_MUL: begin
                ch_idx_d = last_ch_s ? {CIW{1'b0}} : ch_idx_q + CIW'(1);
`ifdef NODE_UNARY_MAC_SAT_EN
                // Once clamped the accumulator stays at full scale for the frame.
                if (carry_s || ovf_q) begin
                    acc_d = {ACC_W{1'b1}};
                end else begin
                    acc_d = sum_s[ACC_W-1:0];
                end
`else
                acc_d = sum_s[ACC_W-1:0];
`endif
                ovf_d = ovf_q | carry_s;
                // Arithmetic still uses the popcount of an illegal code.
                err_d = err_q | ~therm_ok_f(a_ch_s) | ~therm_ok_f(b_ch_s);
            end
            ST_HOLD: begin
                if (out_ready) begin
                    acc_d = {ACC_W{1'b0}};
                    ovf_d = 1'b0;
                    err_d = 1'b0;
                end else begin
                    acc_d = acc_q;
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= {(NCH*UWIDTH){1'b0}};
            b_q      <= {(NCH*UWIDTH){1'b0}};
            last_q   <= 1'b0;
            ch_idx_q <= {CIW{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            last_q   <= last_d;
            ch_idx_q <= ch_idx_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

endmodule
